branch_predictor: RTL

- Direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters.
- In IF: looks up pc_f and produces the prediction triplet (branchfound, branchtaken, pcbranch). The ID/EXE register carries that triplet to EXE.
- In EXE: consumes the carried triplet and the resolved outcome. Flags mispredicts, supplies the redirect PC, updates the table and keeps performance counters.

---
 rtl/branch_predictor.sv | 102 ++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
// Combinational lookup in IF; mispredict detection, table update and statistics in EXE.
module branch_predictor #(
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_f,
  output logic        branchfound_f,
  output logic        branchtaken_f,
  output logic [31:0] pcbranch_f,
  input  logic        stall_e,
  input  logic        isbranch_e,
  input  logic        actualtaken_e,
  input  logic [31:0] target_e,
  input  logic [31:0] pc_e,
  input  logic        branchfound_e,
  input  logic        branchtaken_e,
  input  logic [31:0] pcbranch_e,
  output logic        mispredict_e,
  output logic [31:0] redirect_pc_e,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int unsigned TAG_BITS = 30 - INDEX_BITS;
  localparam int unsigned ENTRIES  = 1 << INDEX_BITS;

  logic [ENTRIES-1:0]  valid;
  logic [1:0]          ctr    [ENTRIES];
  logic [TAG_BITS-1:0] tag    [ENTRIES];
  logic [31:0]         target [ENTRIES];

  logic [INDEX_BITS-1:0] idx_f, idx_e;
  logic [TAG_BITS-1:0]   tag_f, tag_e;
  logic                  hit_f, hit_e, pt;
  logic                  unused_pc_bits;

  assign idx_f = pc_f[INDEX_BITS+1:2];
  assign tag_f = pc_f[31:INDEX_BITS+2];
  assign idx_e = pc_e[INDEX_BITS+1:2];
  assign tag_e = pc_e[31:INDEX_BITS+2];
  assign unused_pc_bits = ^{pc_f[1:0], pc_e[1:0]};

  always_comb begin
    hit_f         = valid[idx_f] && (tag[idx_f] == tag_f);
    branchfound_f = hit_f;
    branchtaken_f = hit_f && ctr[idx_f][1];
    pcbranch_f    = hit_f ? target[idx_f] : '0;
  end

  // Hit is re-evaluated against current contents: the entry may have been
  // replaced after this instruction was fetched.
  assign hit_e = valid[idx_e] && (tag[idx_e] == tag_e);
  assign pt    = branchfound_e && branchtaken_e;

  always_comb begin
    mispredict_e  = 1'b0;
    redirect_pc_e = '0;
    if (!stall_e) begin
      if (isbranch_e && actualtaken_e && (!pt || (pcbranch_e != target_e))) begin
        mispredict_e  = 1'b1;
        redirect_pc_e = target_e;
      end else if (pt && (!isbranch_e || !actualtaken_e)) begin
        mispredict_e  = 1'b1;
        redirect_pc_e = pc_e + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid            <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
    end else if (!stall_e) begin
      branch_count     <= branch_count + {31'd0, isbranch_e};
      mispredict_count <= mispredict_count + {31'd0, mispredict_e};
      if (isbranch_e) begin
        valid[idx_e] <= 1'b1;
        if (hit_e) begin
          if (actualtaken_e && (ctr[idx_e] != 2'b11)) ctr[idx_e] <= ctr[idx_e] + 2'd1;
          else if (!actualtaken_e && (ctr[idx_e] != 2'b00)) ctr[idx_e] <= ctr[idx_e] - 2'd1;
        end else begin
          ctr[idx_e] <= actualtaken_e ? 2'b10 : 2'b01;
        end
      end else if (hit_e) begin
        valid[idx_e] <= 1'b0;
      end
    end
  end

  // Tag and target carry no reset; a cleared valid bit masks them.
  always_ff @(posedge clk) begin
    if (!stall_e && isbranch_e) begin
      if (!hit_e) tag[idx_e] <= tag_e;
      if (!hit_e || actualtaken_e) target[idx_e] <= target_e;
    end
  end

endmodule
